// File: rtl/sync_fifo_ctl.sv
// sync_fifo_ctl: single-clock FIFO with binary wrap pointers, fill count,
// programmable almost-full/almost-empty thresholds and sticky overflow/underflow
// error flags.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads;
// when it is undefined, rdata is registered on each accepted pop.
module sync_fifo_ctl #(
  parameter int unsigned DSIZE     = 32,
  parameter int unsigned ASIZE     = 3,
  parameter int unsigned AFULL_TH  = (1 << ASIZE) - 1,
  parameter int unsigned AEMPTY_TH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  input  logic             err_clr,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned    DEPTH     = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_C   = {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0] AFULL_C   = AFULL_TH[ASIZE:0];
  localparam logic [ASIZE:0] AEMPTY_C  = AEMPTY_TH[ASIZE:0];

  logic [ASIZE:0]   wptr_q, wptr_d;
  logic [ASIZE:0]   rptr_q, rptr_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [DSIZE-1:0] mem_q [DEPTH];

  logic [ASIZE-1:0] waddr, raddr;
  logic [ASIZE:0]   count_w;
  logic             full_w, empty_w;
  logic             push, pop;

  // Occupancy and flags decode from registered pointers only.
  always_comb begin
    waddr   = wptr_q[ASIZE-1:0];
    raddr   = rptr_q[ASIZE-1:0];
    count_w = wptr_q - rptr_q;
    full_w  = (count_w == DEPTH_C);
    empty_w = (count_w == '0);
    push    = winc && !full_w;
    pop     = rinc && !empty_w;
  end

  // Next-state for pointers and sticky error flags.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    overflow_d  = (overflow_q  && !err_clr) || (winc && full_w);
    underflow_d = (underflow_q && !err_clr) || (rinc && empty_w);
  end

  // Pointer and error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[waddr] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word shown whenever the FIFO holds data; zero when empty.
  always_comb begin
    rdata = empty_w ? '0 : mem_q[raddr];
  end
`else
  logic [DSIZE-1:0] rdata_q, rdata_d;

  // Read register captures the head word on an accepted pop.
  always_comb begin
    rdata_d = rdata_q;
    if (pop) rdata_d = mem_q[raddr];
  end

  // Registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
`endif

  // Status outputs.
  always_comb begin
    count         = count_w;
    wfull         = full_w;
    rempty        = empty_w;
    walmost_full  = (count_w >= AFULL_C);
    ralmost_empty = (count_w <= AEMPTY_C);
    overflow      = overflow_q;
    underflow     = underflow_q;
  end

endmodule
